// File: rtl/detector_round_ctrl.sv
// detector_round_ctrl: classifies locked detector results, keeps per-player scores and re-arms the detector.
// Optional ARMED-state timeout is built in when DETECTOR_ROUND_TIMEOUT_EN is defined.
module detector_round_ctrl #(
    parameter int SCORE_W        = 4,
    parameter int WIN_SCORE      = 3,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         y_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_id,
    output logic               res_tie,
    output logic [2:0]         res_bits,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [SCORE_W-1:0] score_c,
    output logic               rearm,
    output logic               game_over,
    input  logic               new_game
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    if (WIN_SCORE < 1 || WIN_SCORE >= 2 ** SCORE_W || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("detector_round_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {ARMED, REPORT, HOLD, REARM, WAIT_CLR, GAME_OVER} state_t;
    state_t state, next_state;

    logic [HW-1:0]      hold_cnt;
    logic               tmo_hit;
    logic               accept, multi, scored, won;
    logic [1:0]         first;
    logic [SCORE_W-1:0] win_cur, win_next;
    logic               valid_d, tie_d;
    logic [1:0]         id_d;
    logic [2:0]         bits_d;
    logic [SCORE_W-1:0] a_d, b_d, c_d;

    assign accept   = res_valid && res_ready;
    assign multi    = (y_in[0] & y_in[1]) | (y_in[0] & y_in[2]) | (y_in[1] & y_in[2]);
    assign first    = y_in[0] ? 2'd0 : (y_in[1] ? 2'd1 : 2'd2);
    assign win_cur  = res_id == 2'd0 ? score_a : (res_id == 2'd1 ? score_b : score_c);
    assign win_next = &win_cur ? win_cur : win_cur + 1'b1;
    assign scored   = state == REPORT && accept && !res_tie && res_id != 2'd3;
    assign won      = scored && win_next >= SCORE_W'(WIN_SCORE);

`ifdef DETECTOR_ROUND_TIMEOUT_EN
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = state == ARMED && y_in == 3'b000 && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt <= '0;
        else     tmo_cnt <= (state == ARMED && y_in == 3'b000 && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARMED;
            hold_cnt  <= '0;
            res_valid <= 1'b0;
            res_id    <= 2'd0;
            res_tie   <= 1'b0;
            res_bits  <= 3'b000;
            score_a   <= '0;
            score_b   <= '0;
            score_c   <= '0;
            rearm     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= next_state;
            hold_cnt  <= state == HOLD ? hold_cnt + 1'b1 : '0;
            res_valid <= valid_d;
            res_id    <= id_d;
            res_tie   <= tie_d;
            res_bits  <= bits_d;
            score_a   <= a_d;
            score_b   <= b_d;
            score_c   <= c_d;
            rearm     <= next_state == REARM;
            game_over <= next_state == GAME_OVER;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARMED:     if (y_in != 3'b000 || tmo_hit) next_state = REPORT;
            REPORT:    if (accept) next_state = won ? GAME_OVER : (HOLD_CYCLES == 0 ? REARM : HOLD);
            HOLD:      if (hold_cnt == HW'(HOLD_CYCLES - 1)) next_state = REARM;
            REARM:     next_state = WAIT_CLR;
            WAIT_CLR:  if (y_in == 3'b000) next_state = ARMED;
            GAME_OVER: if (new_game) next_state = REARM;
            default:   next_state = ARMED;
        endcase
    end

    // Result fields only change when a new round is latched, so they stay stable through REPORT.
    always_comb begin
        valid_d = res_valid;
        id_d    = res_id;
        tie_d   = res_tie;
        bits_d  = res_bits;
        a_d     = score_a;
        b_d     = score_b;
        c_d     = score_c;
        if (state == ARMED && y_in != 3'b000) begin
            valid_d = 1'b1;
            bits_d  = y_in;
            tie_d   = multi;
            id_d    = multi ? 2'd0 : first;
        end else if (tmo_hit) begin
            valid_d = 1'b1;
            bits_d  = 3'b000;
            tie_d   = 1'b0;
            id_d    = 2'd3;
        end
        if (state == REPORT && accept) valid_d = 1'b0;
        if (scored) begin
            a_d = res_id == 2'd0 ? win_next : score_a;
            b_d = res_id == 2'd1 ? win_next : score_b;
            c_d = res_id == 2'd2 ? win_next : score_c;
        end
        if (state == GAME_OVER && new_game) begin
            a_d = '0;
            b_d = '0;
            c_d = '0;
        end
    end
endmodule
